// File: rtl/reg_skid_buffer.sv
// reg_skid_buffer: two-entry valid/ready pipeline stage with registered outputs.
// A main slot drives Q and a skid slot absorbs the one word that can arrive on
// the edge where the consumer stalls. D_READY is a flop, so no combinational path
// runs from Q_READY to D_READY. Words stay in order, and none are lost or duplicated.
//
// Ports:
//   C          in   clock, rising edge
//   R          in   synchronous active-high reset
//   D          in   upstream data [DATA_WIDTH]
//   D_VALID    in   upstream word present
//   D_READY    out  buffer can accept (registered)
//   Q          out  downstream data [DATA_WIDTH]
//   Q_VALID    out  Q holds a valid word (registered)
//   Q_READY    in   downstream accepts Q
//   XFER_CNT   out  output transfers, wraps [CNT_WIDTH]
//   STALL_CNT  out  cycles with Q_VALID & ~Q_READY, saturates [CNT_WIDTH]
module reg_skid_buffer #(
  parameter int unsigned                DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]      INIT_VAL   = '0,
  parameter int unsigned                CNT_WIDTH  = 8
) (
  input  logic                  C,
  input  logic                  R,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  D_VALID,
  output logic                  D_READY,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VALID,
  input  logic                  Q_READY,
  output logic [CNT_WIDTH-1:0]  XFER_CNT,
  output logic [CNT_WIDTH-1:0]  STALL_CNT
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  state_t                r_state;
  state_t                w_state_d;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] w_main_d;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [DATA_WIDTH-1:0] w_skid_d;
  logic                  r_ready;
  logic                  r_q_valid;
  logic [CNT_WIDTH-1:0]  r_xfer;
  logic [CNT_WIDTH-1:0]  r_stall;

  logic w_in;
  logic w_out;

  assign w_in  = D_VALID & r_ready;
  assign w_out = r_q_valid & Q_READY;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    case (r_state)
      StEmpty: begin
        if (w_in) begin
          w_state_d = StOne;
          w_main_d  = D;
        end
      end
      StOne: begin
        if (w_in && w_out) begin
          w_main_d = D;
        end else if (w_in) begin
          // Consumer stalled: park the new word, keep Q stable.
          w_state_d = StTwo;
          w_skid_d  = D;
        end else if (w_out) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: begin
        if (w_out) begin
          w_state_d = StOne;
          w_main_d  = r_skid;
        end
      end
      default: begin
        w_state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state   <= StEmpty;
      r_main    <= INIT_VAL;
      r_skid    <= INIT_VAL;
      r_ready   <= 1'b0;
      r_q_valid <= 1'b0;
      r_xfer    <= '0;
      r_stall   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_main    <= w_main_d;
      r_skid    <= w_skid_d;
      // Ready and valid are registered copies of the next-state decode.
      r_ready   <= (w_state_d != StTwo);
      r_q_valid <= (w_state_d != StEmpty);
      if (w_out) begin
        r_xfer <= r_xfer + CntOne;
      end
      if (r_q_valid && !Q_READY && (r_stall != '1)) begin
        r_stall <= r_stall + CntOne;
      end
    end
  end

  assign D_READY   = r_ready;
  assign Q         = r_main;
  assign Q_VALID   = r_q_valid;
  assign XFER_CNT  = r_xfer;
  assign STALL_CNT = r_stall;

endmodule

// File: doc/reg_skid_buffer.md
# reg_skid_buffer

Two-entry valid/ready pipeline stage with synchronous reset. It sits directly upstream of the `register` block and feeds its `D` input from a producer that can be back-pressured. Every output is registered, so no combinational path runs from `Q_READY` to `D_READY`. Ordering is preserved, and a stalled consumer never loses or duplicates a word. Two counters, for transfers and stall cycles, support debug and performance checks.

## Interface
Parameters:
- `DATA_WIDTH`, 4: width of the data path.
- `INIT_VAL`, 0: value driven on `Q` while reset and after reset, until the first accepted word.
- `CNT_WIDTH`, 8: width of `XFER_CNT` and `STALL_CNT`.

Ports:
- `C`, input, 1: clock; all state changes on the rising edge.
- `R`, input, 1: reset, synchronous and active-high; sampled on the rising edge of `C`.
- `D`, input, `DATA_WIDTH`: upstream data.
- `D_VALID`, input, 1: upstream word present on `D`.
- `D_READY`, output, 1: buffer can accept; registered.
- `Q`, output, `DATA_WIDTH`: downstream data, feeding `register.D`.
- `Q_VALID`, output, 1: `Q` holds a valid word.
- `Q_READY`, input, 1: downstream accepts `Q` this cycle.
- `XFER_CNT`, output, `CNT_WIDTH`: number of output transfers, modulo 2^`CNT_WIDTH`.
- `STALL_CNT`, output, `CNT_WIDTH`: number of cycles with `Q_VALID`=1 and `Q_READY`=0; saturates at all-ones.

## Operation
- **Transfers.**
  - Input transfer (IN): `D_VALID`=1 and `D_READY`=1 at a rising edge.
  - Output transfer (OUT): `Q_VALID`=1 and `Q_READY`=1 at a rising edge.
- **Storage.** There are two slots: a main slot, which drives `Q`, and a skid slot.
- **States.**
  - EMPTY: `Q_VALID`=0, `D_READY`=1.
  - ONE: `Q_VALID`=1, skid slot empty, `D_READY`=1.
  - TWO: `Q_VALID`=1, skid slot full, `D_READY`=0.
- **Transitions** (evaluated at each rising edge with `R`=0):
  - EMPTY, IN: go to ONE; main <= `D`.
  - EMPTY, no IN: stay in EMPTY; `Q` holds its last value.
  - ONE, IN and OUT: stay in ONE; main <= `D`.
  - ONE, IN only: go to TWO; skid <= `D`; main unchanged.
  - ONE, OUT only: go to EMPTY; `Q` holds its value.
  - ONE, neither: stay in ONE.
  - TWO, OUT: go to ONE; main <= skid. IN cannot occur because `D_READY`=0.
  - TWO, no OUT: stay in TWO; both slots hold.
- **Stable output.** While `Q_VALID`=1 and `Q_READY`=0, `Q` does not change.
- **Ready is a flop.** `D_READY` is the registered next-state value: 1 exactly when the next state is EMPTY or ONE.
- **`D_VALID` while not ready.** `D_VALID`=1 while `D_READY`=0 is not a transfer. `D` is ignored.
- **`XFER_CNT`.** Increments by 1 on each OUT and wraps from all-ones to 0.
- **`STALL_CNT`.** Increments by 1 on each edge with `Q_VALID`=1 and `Q_READY`=0. It holds at all-ones once saturated and does not wrap.
- **Reset.** When `R`=1 at an edge:
  - state becomes EMPTY;
  - `Q` = `INIT_VAL`, `Q_VALID` = 0;
  - `D_READY` = 0;
  - `XFER_CNT` = 0, `STALL_CNT` = 0;
  - skid contents are discarded.
- **Reset priority.** Reset overrides any simultaneous IN or OUT. Words held at reset are dropped, and the counters do not count those edges.
- **After reset.** On the first edge with `R`=0, `D_READY` goes to 1. No IN is possible on that edge.

## Timing
- **Latency.** From EMPTY, a word accepted at edge k drives `Q` with `Q_VALID`=1 from edge k up to edge k+1. The downstream `register` then captures it at edge k+1.
- **Throughput.** With `Q_READY` held at 1, one word is transferred per cycle indefinitely.
- **Ready timing.** `D_READY` falls in the cycle after the entering-TWO edge. The word that arrives on that edge is absorbed by the skid slot, so no word is lost.
- **Ready recovery.** `D_READY` rises in the cycle after the first OUT from TWO.
- **Mid-operation reset.** A one-cycle `R` pulse in state TWO produces `Q_VALID`=0 and `Q`=`INIT_VAL` from the next edge. `D_READY` is 0 for that one cycle and 1 after the following edge.

## Test plan
Parameters for all scenarios: `DATA_WIDTH`=4, `INIT_VAL`=0, `CNT_WIDTH`=8.

1. **Reset.** Hold `R`=1 for 2 edges with `D_VALID`=1 and `D`=5. Required: `Q`=0, `Q_VALID`=0, `D_READY`=0, both counters 0. One edge after release, `D_READY`=1.
2. **Streaming.** Present `D`=1,2,3,…,15,0 with `D_VALID`=1 and `Q_READY`=1. Required: `Q` follows one cycle later with no gaps, and `XFER_CNT` reaches 16 after 16 outputs.
3. **Back-pressure.** Drop `Q_READY` for 3 cycles while `D`=7,8,9 is offered.
   - Required: `Q` holds 7; `D_READY`=0 after 8 is skidded; 9 is held upstream; `STALL_CNT`=3.
   - After `Q_READY` returns to 1, `Q` presents 7,8,9 in order with no loss.
4. **Saturation and wrap.** Hold `Q_READY`=0 for 300 cycles. Required: `STALL_CNT`=255 and holds there. Then stream 260 transfers. Required: `XFER_CNT`=4.
5. **Reset in TWO.** Enter TWO holding words 3 and 4, then pulse `R`=1 for one edge. Required: `Q_VALID`=0 and `Q`=0. The next accepted word, 6, appears on `Q`, and neither 3 nor 4 ever appears.
6. **Drain to EMPTY.** From ONE holding word 2, send `D_VALID`=0 and `Q_READY`=1. Required: state EMPTY, `Q_VALID`=0, and `Q` stays at 2.
